// File: rtl/fb_pixel_writer_pkg.sv
// Shared frame-buffer definitions: screen geometry, colours, FIFO entry
// layout, writer FSM states and coordinate linearisation.
package fb_pixel_writer_pkg;

    localparam int unsigned SCREEN_W  = 160;
    localparam int unsigned SCREEN_H  = 120;
    localparam int unsigned FB_ADDR_W = 15;

    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] WHITE  = 3'b111;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN
    } fb_state_t;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [2:0]           colour;
    } fb_pix_t;

    // y*160 + x without a multiplier
    function automatic logic [FB_ADDR_W-1:0] fb_lin_addr(input logic [6:0] x,
                                                         input logic [6:0] y);
        logic [FB_ADDR_W-1:0] yw;
        yw = {8'b0, y};
        return (yw << 7) + (yw << 5) + {8'b0, x};
    endfunction

endpackage

// File: rtl/fb_pixel_writer_fifo.sv
// fb_pixel_fifo: synchronous FIFO with full/empty flags. Head entry is
// presented combinationally on o_rdata; DEPTH must be a power of two.
module fb_pixel_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clock,
    input  logic             i_resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;

    // Entry storage; no reset needed, validity tracked by r_count
    always_ff @(posedge i_clock) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally; count unchanged on simultaneous push/pop
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: buffers renderer pixels, linearises (x,y) into frame
// buffer addresses and writes them out; sweeps the screen to CLEAR_COLOUR
// after reset and on clear_req.
// Optional: FB_DROP_COUNT_EN adds drop_count (saturating count of
// out-of-range pixels, zeroed at reset and at the start of every clear).
module fb_pixel_writer #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned SCREEN_W     = fb_pixel_writer_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H     = fb_pixel_writer_pkg::SCREEN_H,
    parameter logic [2:0]  CLEAR_COLOUR = fb_pixel_writer_pkg::BLACK
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_x,
    input  logic [6:0]  in_y,
    input  logic [2:0]  in_colour,
    input  logic        clear_req,
    output logic        busy,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        mem_we,
    input  logic        mem_ready
`ifdef FB_DROP_COUNT_EN
    ,
    output logic [7:0]  drop_count
`endif
);

    import fb_pixel_writer_pkg::*;

    localparam logic [14:0] LAST_ADDR = 15'(SCREEN_W * SCREEN_H - 1);

    fb_state_t r_state;
    fb_state_t w_next_state;
    logic        r_active;
    logic [14:0] r_sweep;
    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_x_ok;
    logic        w_y_ok;
    logic        w_in_range;
    logic        w_push;
    logic        w_pop;
    logic        w_clear_start;
    fb_pix_t     w_push_pix;
    fb_pix_t     w_head;

    // A 7-bit coordinate cannot reach a limit >= 128, so the compare only
    // exists for narrower screens
    if (SCREEN_W >= 128) begin : g_x_all
        assign w_x_ok = 1'b1;
    end else begin : g_x_chk
        assign w_x_ok = ({1'b0, in_x} < 8'(SCREEN_W));
    end
    if (SCREEN_H >= 128) begin : g_y_all
        assign w_y_ok = 1'b1;
    end else begin : g_y_chk
        assign w_y_ok = ({1'b0, in_y} < 8'(SCREEN_H));
    end

    assign w_in_range = w_x_ok && w_y_ok;
    assign w_accept   = in_valid && in_ready;
    assign w_push     = w_accept && w_in_range;
    assign w_push_pix = '{addr: fb_lin_addr(in_x, in_y), colour: in_colour};

    fb_pixel_fifo #(
        .WIDTH($bits(fb_pix_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clock (clock),
        .i_resetn(resetn),
        .i_push  (w_push),
        .i_wdata (w_push_pix),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Holds every output quiet until the first clock after reset release
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_active <= 1'b0;
        else         r_active <= 1'b1;
    end

    // FSM state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= ST_CLEAR;
        else         r_state <= w_next_state;
    end

    // Next state, handshake and write-port outputs
    always_comb begin
        w_next_state  = r_state;
        in_ready      = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_data      = '0;
        w_pop         = 1'b0;
        w_clear_start = 1'b0;
        busy          = 1'b0;
        if (r_active) begin
            busy = (r_state != ST_RUN) || !w_empty;
            case (r_state)
                ST_CLEAR: begin
                    mem_we   = 1'b1;
                    mem_addr = r_sweep;
                    mem_data = CLEAR_COLOUR;
                    if (mem_ready && (r_sweep == LAST_ADDR)) w_next_state = ST_RUN;
                end
                ST_RUN: begin
                    in_ready = !w_full;
                    mem_we   = !w_empty;
                    mem_addr = w_head.addr;
                    mem_data = w_head.colour;
                    w_pop    = !w_empty && mem_ready;
                    if (clear_req) w_next_state = ST_DRAIN;
                end
                ST_DRAIN: begin
                    mem_we   = !w_empty;
                    mem_addr = w_head.addr;
                    mem_data = w_head.colour;
                    w_pop    = !w_empty && mem_ready;
                    if (w_empty) begin
                        w_clear_start = 1'b1;
                        w_next_state  = ST_CLEAR;
                    end
                end
                default: w_next_state = ST_CLEAR;
            endcase
        end
    end

    // Clear sweep address, advanced on each accepted clear write
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sweep <= '0;
        end else if (r_active && (r_state == ST_CLEAR) && mem_ready) begin
            r_sweep <= (r_sweep == LAST_ADDR) ? '0 : r_sweep + 15'd1;
        end else if (w_clear_start) begin
            r_sweep <= '0;
        end
    end

`ifdef FB_DROP_COUNT_EN
    logic [7:0] r_drop_cnt;

    // Saturating count of consumed out-of-range pixels
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_drop_cnt <= '0;
        end else if (w_clear_start) begin
            r_drop_cnt <= '0;
        end else if (w_accept && !w_in_range && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_count = r_drop_cnt;
`endif

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed self-checking bench for fb_pixel_writer.
module tb_fb_pixel_writer;

    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_x = '0;
    logic [6:0]  in_y = '0;
    logic [2:0]  in_colour = '0;
    logic        clear_req = 1'b0;
    logic        busy;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic        mem_ready = 1'b0;
`ifdef FB_DROP_COUNT_EN
    logic [7:0]  drop_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Backpressure vectors: pixel coordinates, colours, hand-computed addresses
    logic [6:0]  bp_x [5] = '{7'd0, 7'd1, 7'd127, 7'd10, 7'd3};
    logic [6:0]  bp_y [5] = '{7'd0, 7'd2, 7'd119, 7'd100, 7'd1};
    logic [2:0]  bp_c [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [14:0] bp_a [5] = '{15'd0, 15'd321, 15'd19167, 15'd16010, 15'd163};

    fb_pixel_writer #(
        .FIFO_DEPTH  (4),
        .SCREEN_W    (160),
        .SCREEN_H    (120),
        .CLEAR_COLOUR(3'b000)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_y     (in_y),
        .in_colour(in_colour),
        .clear_req(clear_req),
        .busy     (busy),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .mem_ready(mem_ready)
`ifdef FB_DROP_COUNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #1 resetn = 1'b0;
        mem_ready = 1'b1;
        #2;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_checks++;
        if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        n_checks++;
        if (mem_addr !== 15'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
        n_checks++;
        if (mem_data !== 3'd0) begin n_fail++; $display("FAIL reset_mem_data: got %0d want 0", mem_data); end
        step();
        step();
        n_checks++;
        if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_hold_we: got %b want 0", mem_we); end
        resetn = 1'b1;
    endtask

    task automatic test_initial_clear();
        int exp_addr;
        int bad;
        int cycles;
        step();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL clear_busy_first: got %b want 1", busy); end
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 15'd0) begin
            n_fail++; $display("FAIL clear_first_write: we=%b addr=%0d want we=1 addr=0", mem_we, mem_addr);
        end
        exp_addr = 1;
        bad = 0;
        cycles = 0;
        while (exp_addr < 19200 && cycles < 25000) begin
            step();
            cycles++;
            if (mem_we) begin
                if (mem_addr !== 15'(exp_addr) || mem_data !== 3'd0 || in_ready !== 1'b0) bad++;
                exp_addr++;
            end
        end
        n_checks++;
        if (exp_addr !== 19200) begin n_fail++; $display("FAIL clear_write_count: got %0d want 19200", exp_addr); end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL clear_sequence: %0d bad writes want 0", bad); end
        step();
        n_checks++;
        if (mem_we !== 1'b0) begin n_fail++; $display("FAIL clear_end_we: got %b want 0", mem_we); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL clear_end_ready: got %b want 1", in_ready); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_end_busy: got %b want 0", busy); end
    endtask

    task automatic test_single_pixel();
        mem_ready = 1'b1;
        in_valid = 1'b1; in_x = 7'd57; in_y = 7'd27; in_colour = 3'b111;
        n_checks++;
        if (mem_we !== 1'b0) begin n_fail++; $display("FAIL single_no_comb_path: got %b want 0", mem_we); end
        step();
        in_valid = 1'b0;
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 15'd4377 || mem_data !== 3'b111) begin
            n_fail++; $display("FAIL single_write: we=%b addr=%0d data=%0d want 1/4377/7", mem_we, mem_addr, mem_data);
        end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
        step();
        n_checks++;
        if (busy !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL single_after_pop: busy=%b we=%b want 0/0", busy, mem_we);
        end
    endtask

    task automatic test_backpressure();
        int k;
        int bad;
        bit acc;
        bit acc4;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_x = bp_x[i]; in_y = bp_y[i]; in_colour = bp_c[i];
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_%0d: got %b want 1", i, in_ready); end
            step();
        end
        in_x = bp_x[4]; in_y = bp_y[4]; in_colour = bp_c[4];
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
        step();
        step();
        n_checks++;
        if (in_ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 15'd0 || mem_data !== 3'd1) begin
            n_fail++; $display("FAIL bp_hold: ready=%b we=%b addr=%0d data=%0d want 0/1/0/1", in_ready, mem_we, mem_addr, mem_data);
        end
        mem_ready = 1'b1;
        k = 0; bad = 0; acc4 = 1'b0;
        for (int cyc = 0; cyc < 20 && k < 5; cyc++) begin
            if (mem_we) begin
                if (mem_addr !== bp_a[k] || mem_data !== bp_c[k]) bad++;
                k++;
            end
            acc = in_valid && in_ready;
            step();
            if (acc) begin in_valid = 1'b0; acc4 = 1'b1; end
        end
        n_checks++;
        if (k !== 5) begin n_fail++; $display("FAIL bp_write_count: got %0d want 5", k); end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL bp_order: %0d bad writes want 0", bad); end
        n_checks++;
        if (acc4 !== 1'b1) begin n_fail++; $display("FAIL bp_fifth_accepted: got %b want 1", acc4); end
        step();
        n_checks++;
        if (mem_we !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_idle: we=%b busy=%b want 0/0", mem_we, busy);
        end
    endtask

    task automatic test_drop();
        mem_ready = 1'b1;
        in_valid = 1'b1; in_x = 7'd0; in_y = 7'd120; in_colour = 3'b110;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drop_ready_a: got %b want 1", in_ready); end
        step();
        in_x = 7'd5; in_y = 7'd127; in_colour = 3'b100;
        n_checks++;
        if (mem_we !== 1'b0) begin n_fail++; $display("FAIL drop_we_a: got %b want 0", mem_we); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drop_ready_b: got %b want 1", in_ready); end
        step();
        in_x = 7'd127; in_y = 7'd0; in_colour = 3'b111;
        n_checks++;
        if (mem_we !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL drop_we_b: we=%b busy=%b want 0/0", mem_we, busy);
        end
        step();
        in_valid = 1'b0;
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 15'd127 || mem_data !== 3'b111) begin
            n_fail++; $display("FAIL drop_edge_x127: we=%b addr=%0d data=%0d want 1/127/7", mem_we, mem_addr, mem_data);
        end
        step();
`ifdef FB_DROP_COUNT_EN
        n_checks++;
        if (drop_count !== 8'd2) begin n_fail++; $display("FAIL drop_count: got %0d want 2", drop_count); end
`endif
    endtask

    task automatic test_clear_drain();
        int k;
        int bad;
        int exp_a;
        int exp_d;
        bit pulsed;
        mem_ready = 1'b0;
        in_valid = 1'b1; in_x = 7'd1; in_y = 7'd1; in_colour = 3'd6;
        step();
        in_x = 7'd2; in_y = 7'd3; in_colour = 3'd5;
        step();
        in_x = 7'd4; in_y = 7'd5; in_colour = 3'd4; clear_req = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_accept_with_clear: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0; clear_req = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL drain_entry: ready=%b busy=%b want 0/1", in_ready, busy);
        end
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 15'd161) begin
            n_fail++; $display("FAIL drain_head: we=%b addr=%0d want 1/161", mem_we, mem_addr);
        end
        mem_ready = 1'b1;
        k = 0; bad = 0; pulsed = 1'b0;
        for (int cyc = 0; cyc < 40 && k < 13; cyc++) begin
            if (in_ready !== 1'b0) bad++;
            if (mem_we) begin
                case (k)
                    0:       begin exp_a = 161; exp_d = 6; end
                    1:       begin exp_a = 482; exp_d = 5; end
                    2:       begin exp_a = 804; exp_d = 4; end
                    default: begin exp_a = k - 3; exp_d = 0; end
                endcase
                if (mem_addr !== 15'(exp_a) || mem_data !== 3'(exp_d)) bad++;
                k++;
            end
            clear_req = (k == 8) && !pulsed;
            if (clear_req) pulsed = 1'b1;
            step();
        end
        clear_req = 1'b0;
        n_checks++;
        if (k !== 13) begin n_fail++; $display("FAIL drain_write_count: got %0d want 13", k); end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL drain_sequence: %0d bad cycles want 0", bad); end
    endtask

    task automatic test_reset_mid_sweep();
        bit found;
        found = 1'b0;
        mem_ready = 1'b1;
        for (int cyc = 0; cyc < 6000 && !found; cyc++) begin
            if (mem_we && mem_addr == 15'd5000) found = 1'b1;
            else step();
        end
        n_checks++;
        if (found !== 1'b1) begin n_fail++; $display("FAIL midreset_reach_5000: got %b want 1", found); end
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if (mem_we !== 1'b0 || in_ready !== 1'b0 || mem_addr !== 15'd0) begin
            n_fail++; $display("FAIL midreset_async: we=%b ready=%b addr=%0d want 0/0/0", mem_we, in_ready, mem_addr);
        end
        step();
        step();
        resetn = 1'b1;
        step();
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 15'd0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL midreset_restart: we=%b addr=%0d busy=%b want 1/0/1", mem_we, mem_addr, busy);
        end
        step();
        step();
        n_checks++;
        if (mem_addr !== 15'd2) begin n_fail++; $display("FAIL midreset_advance: got %0d want 2", mem_addr); end
    endtask

    initial begin
        test_reset();
        test_initial_clear();
        test_single_pixel();
        test_backpressure();
        test_drop();
        test_clear_drain();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
